slap_palette_pipe: RTL and testbench
====================================

Name: slap_palette_pipe

Overview:
- Final colour stage of the video path; sits between the layer generators and the 256x4 colour PROMs (red, green and blue).
- Per pixel it picks the winning layer from fix, sprite and background by priority and transparency.
- It drives the shared 8-bit address and active-low chip-select of the three colour PROMs and captures their 4-bit outputs.
- It emits blank-gated 4:4:4 RGB with hsync, vsync and blank delayed to match the pipeline.

Parameters:
- TRANSP_NIB, 4'h0: low-nibble value that marks a fix or sprite pixel transparent.
- BLANK_RGB, 12'h000: RGB value driven during blanking, as {r,g,b}.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- pix_ce  in  1  pixel clock enable; inputs are sampled only on clk edges where pix_ce=1.
- fix_pix  in  8  fix/char layer colour index.
- spr_pix  in  8  sprite layer colour index.
- bg_pix  in  8  background layer colour index; always opaque.
- layer_en  in  3  per-layer enable, bit2=fix, bit1=spr, bit0=bg; a disabled layer is treated as transparent (bg becomes index 8'h00).
- hblank, vblank, hsync, vsync  in  1 each  timing from the video timing generator.
- prom_addr  out  8  colour PROM address.
- prom_n_cs  out  1  colour PROM chip select, active low.
- prom_r, prom_g, prom_b  in  4 each  registered PROM data.
- red, green, blue  out  4 each  final pixel colour.
- hs_out, vs_out, blank_out  out  1 each  delay-matched timing.

Behaviour:
- One clock domain. Reset is synchronous and active-high; it takes priority over pix_ce.
- Reset values:
  - idx_q=0, prom_n_cs=1, ce_d1=0, ce_d2=0.
  - red/green/blue=0, hs_out=0, vs_out=0, blank_out=1.
  - All timing delay registers: blank stages=1, sync stages=0.
- Priority mux (combinational):
  - fix wins if layer_en[2] and fix_pix[3:0]!=TRANSP_NIB.
  - Else spr wins if layer_en[1] and spr_pix[3:0]!=TRANSP_NIB.
  - Else bg_pix if layer_en[0].
  - Else 8'h00.
- Pipeline timing (E0 = clk edge with pix_ce=1):
  - E0: idx_q <= mux result. {hblank|vblank, hsync, vsync} go into delay stage 1. ce_d1 <= 1.
  - Between E0 and E1: prom_addr=idx_q (always driven from idx_q) and prom_n_cs=~ce_d1, so it is low for exactly one clk.
  - E1: the PROMs latch q. ce_d2 <= ce_d1. Timing moves to stage 2.
  - E2 (ce_d2=1): {red,green,blue} <= blank_d2 ? BLANK_RGB : {prom_r,prom_g,prom_b}. hs_out, vs_out and blank_out update from stage 2 on the same edge.
  - Latency: outputs reflect a pixel sampled at E0 immediately after E2, i.e. 2 clk after sampling. All timing outputs are exactly aligned with the RGB they accompany.
- pix_ce may be asserted on consecutive clks (1 pixel/clk). The pipeline is fully pipelined with no stall.
- Outputs change only on E2-type edges; they hold their value while ce_d2=0.
- pix_ce=0 indefinitely: prom_n_cs stays 1 and outputs hold.
- Reset mid-frame: in-flight pixels are discarded and outputs go to reset values on the next edge. The first valid pixel appears 2 clk after the first post-reset pix_ce.
- layer_en changes take effect at the next sampling edge; no glitch is allowed on in-flight pixels.

Decomposition:
- Shared package slap_video_pkg holds:
  - PAL_PIPE_LAT=2
  - LAYER_FIX/LAYER_SPR/LAYER_BG bit-index constants
  - a typedef for the 12-bit rgb444 struct {r,g,b}
  - the TRANSP_NIB default
- One natural sub-module, slap_prio_mux: the purely combinational priority/transparency select, reused by the sprite debug viewer.
- The delay line stays inline.

Test Plan:
- Setup: PROM models with r=addr[3:0], g=addr[7:4], b=~addr[3:0].
- fix=8'h35, spr=8'h47, bg=8'h12, layer_en=3'b111, one pix_ce pulse, no blank -> prom_addr=8'h35 with prom_n_cs=0 for one clk; 2 clk later {red,green,blue}={4'h5,4'h3,4'hA}.
- fix=8'h30 (transparent), spr=8'h47 -> output {7,4,8}. Then spr=8'h40 as well -> bg 8'h12 gives {2,1,D}.
- layer_en=3'b000 with any pixels -> index 8'h00 -> output {0,0,F}. layer_en=3'b011 with fix=8'h35 -> sprite wins.
- pix_ce every clk, 16-pixel ramp bg=0..15, hblank high for pixels 10-12 -> RGB=0 exactly on outputs 10-12; blank_out and hs_out edges coincide with those RGB changes.
- pix_ce every 4th clk -> outputs change only 2 clk after each pulse; prom_n_cs low one clk per pulse, otherwise high.
- Assert reset for 1 clk mid-stream with pixels in flight -> next edge gives RGB=0, blank_out=1, hs_out=vs_out=0, prom_n_cs=1; no stale pixel emerges afterwards.

Source files
------------

// File: rtl/slap_video_pkg.sv
// slap_video_pkg
// Shared definitions for the SLAP video path: palette pipeline latency,
// layer-enable bit positions, the 4:4:4 colour struct and the default
// transparent nibble used by the fix and sprite layers.
package slap_video_pkg;

  // Clocks from pixel sampling to the colour appearing on the outputs.
  localparam int PAL_PIPE_LAT = 2;

  // Bit positions inside the 3-bit layer_en vector.
  localparam int LAYER_FIX = 2;
  localparam int LAYER_SPR = 1;
  localparam int LAYER_BG  = 0;

  // Low-nibble value that marks a fix or sprite pixel as see-through.
  localparam logic [3:0] TRANSP_NIB_DEF = 4'h0;

  // One 12-bit pixel colour, packed as {r,g,b}.
  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

endpackage

// File: rtl/slap_prio_mux.sv
// slap_prio_mux
// Purely combinational layer select: picks fix over sprite over background
// by priority, skipping layers that are disabled or transparent. Also used
// by the sprite debug viewer.
// Ports:
//   fix_pix, spr_pix, bg_pix : 8-bit colour indices from the layer generators
//   layer_en                 : per-layer enable {fix, spr, bg}
//   idx                      : winning colour index (8'h00 if nothing wins)
module slap_prio_mux
  import slap_video_pkg::*;
#(
  parameter logic [3:0] TRANSP_NIB = TRANSP_NIB_DEF
) (
  input  logic [7:0] fix_pix,
  input  logic [7:0] spr_pix,
  input  logic [7:0] bg_pix,
  input  logic [2:0] layer_en,
  output logic [7:0] idx
);

  // Background is always opaque, so it only drops out when disabled; a
  // fully disabled stack falls back to palette entry 0.
  always_comb begin
    idx = 8'h00;
    if (layer_en[LAYER_FIX] && (fix_pix[3:0] != TRANSP_NIB)) begin
      idx = fix_pix;
    end else if (layer_en[LAYER_SPR] && (spr_pix[3:0] != TRANSP_NIB)) begin
      idx = spr_pix;
    end else if (layer_en[LAYER_BG]) begin
      idx = bg_pix;
    end
  end

endmodule

// File: rtl/slap_palette_pipe.sv
// slap_palette_pipe
// Final colour stage of the video path. Selects the winning layer index,
// drives the three 256x4 colour PROMs (shared address, shared active-low
// chip select), captures their registered data and emits blank-gated RGB
// with sync/blank delayed to line up exactly with the colour.
// Ports:
//   clk, reset            : system clock, synchronous active-high reset
//   pix_ce                : pixel clock enable (inputs sampled when high)
//   fix_pix/spr_pix/bg_pix: layer colour indices
//   layer_en              : per-layer enable {fix, spr, bg}
//   hblank/vblank/hsync/vsync : timing from the video timing generator
//   prom_addr, prom_n_cs  : colour PROM address and chip select
//   prom_r/prom_g/prom_b  : registered PROM data
//   red/green/blue        : final pixel colour
//   hs_out/vs_out/blank_out : timing aligned with the colour outputs
module slap_palette_pipe
  import slap_video_pkg::*;
#(
  parameter logic [3:0]  TRANSP_NIB = TRANSP_NIB_DEF,
  parameter logic [11:0] BLANK_RGB  = 12'h000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_ce,
  input  logic [7:0] fix_pix,
  input  logic [7:0] spr_pix,
  input  logic [7:0] bg_pix,
  input  logic [2:0] layer_en,
  input  logic       hblank,
  input  logic       vblank,
  input  logic       hsync,
  input  logic       vsync,
  output logic [7:0] prom_addr,
  output logic       prom_n_cs,
  input  logic [3:0] prom_r,
  input  logic [3:0] prom_g,
  input  logic [3:0] prom_b,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       hs_out,
  output logic       vs_out,
  output logic       blank_out
);

  logic [7:0] mux_idx;

  logic [7:0] idx_d, idx_q;
  logic       ce_d1_d, ce_d1_q;
  logic       ce_d2_d, ce_d2_q;
  logic       blank_d1_d, blank_d1_q;
  logic       hs_d1_d, hs_d1_q;
  logic       vs_d1_d, vs_d1_q;
  logic       blank_d2_d, blank_d2_q;
  logic       hs_d2_d, hs_d2_q;
  logic       vs_d2_d, vs_d2_q;
  rgb444_t    rgb_d, rgb_q;
  logic       hs_out_d, hs_out_q;
  logic       vs_out_d, vs_out_q;
  logic       blank_out_d, blank_out_q;

  slap_prio_mux #(
    .TRANSP_NIB(TRANSP_NIB)
  ) u_prio_mux (
    .fix_pix (fix_pix),
    .spr_pix (spr_pix),
    .bg_pix  (bg_pix),
    .layer_en(layer_en),
    .idx     (mux_idx)
  );

  // Each stage advances only when the enable that accompanies its pixel is
  // present, so sparse pix_ce leaves every stage (and the outputs) holding.
  // The ce_d* pair marks which clock edges carry a real pixel through the
  // PROM read and the output capture respectively.
  always_comb begin
    idx_d       = idx_q;
    blank_d1_d  = blank_d1_q;
    hs_d1_d     = hs_d1_q;
    vs_d1_d     = vs_d1_q;
    blank_d2_d  = blank_d2_q;
    hs_d2_d     = hs_d2_q;
    vs_d2_d     = vs_d2_q;
    rgb_d       = rgb_q;
    hs_out_d    = hs_out_q;
    vs_out_d    = vs_out_q;
    blank_out_d = blank_out_q;
    ce_d1_d     = pix_ce;
    ce_d2_d     = ce_d1_q;

    if (pix_ce) begin
      idx_d      = mux_idx;
      blank_d1_d = hblank | vblank;
      hs_d1_d    = hsync;
      vs_d1_d    = vsync;
    end

    if (ce_d1_q) begin
      blank_d2_d = blank_d1_q;
      hs_d2_d    = hs_d1_q;
      vs_d2_d    = vs_d1_q;
    end

    // PROM data is valid on this edge because the PROMs latched on the
    // previous one while chip select was low.
    if (ce_d2_q) begin
      rgb_d       = blank_d2_q ? rgb444_t'(BLANK_RGB)
                               : rgb444_t'({prom_r, prom_g, prom_b});
      hs_out_d    = hs_d2_q;
      vs_out_d    = vs_d2_q;
      blank_out_d = blank_d2_q;
    end
  end

  // Reset clears the valid markers so in-flight pixels never reach the
  // outputs; blank stages reset asserted so the screen starts dark.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q       <= 8'h00;
      ce_d1_q     <= 1'b0;
      ce_d2_q     <= 1'b0;
      blank_d1_q  <= 1'b1;
      hs_d1_q     <= 1'b0;
      vs_d1_q     <= 1'b0;
      blank_d2_q  <= 1'b1;
      hs_d2_q     <= 1'b0;
      vs_d2_q     <= 1'b0;
      rgb_q       <= '0;
      hs_out_q    <= 1'b0;
      vs_out_q    <= 1'b0;
      blank_out_q <= 1'b1;
    end else begin
      idx_q       <= idx_d;
      ce_d1_q     <= ce_d1_d;
      ce_d2_q     <= ce_d2_d;
      blank_d1_q  <= blank_d1_d;
      hs_d1_q     <= hs_d1_d;
      vs_d1_q     <= vs_d1_d;
      blank_d2_q  <= blank_d2_d;
      hs_d2_q     <= hs_d2_d;
      vs_d2_q     <= vs_d2_d;
      rgb_q       <= rgb_d;
      hs_out_q    <= hs_out_d;
      vs_out_q    <= vs_out_d;
      blank_out_q <= blank_out_d;
    end
  end

  // The PROM address follows idx_q continuously; chip select is only
  // asserted during the single clock after a sampling edge.
  assign prom_addr = idx_q;
  assign prom_n_cs = ~ce_d1_q;
  assign red       = rgb_q.r;
  assign green     = rgb_q.g;
  assign blue      = rgb_q.b;
  assign hs_out    = hs_out_q;
  assign vs_out    = vs_out_q;
  assign blank_out = blank_out_q;

endmodule

// File: tb/tb_slap_palette_pipe.sv
// tb_slap_palette_pipe
// Directed bench for slap_palette_pipe. Colour PROMs are modelled as
// registered ROMs returning r=addr[3:0], g=addr[7:4], b=~addr[3:0].
module tb_slap_palette_pipe;
  import slap_video_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       pix_ce;
  logic [7:0] fix_pix, spr_pix, bg_pix;
  logic [2:0] layer_en;
  logic       hblank, vblank, hsync, vsync;
  logic [7:0] prom_addr;
  logic       prom_n_cs;
  logic [3:0] prom_r = 4'h0;
  logic [3:0] prom_g = 4'h0;
  logic [3:0] prom_b = 4'h0;
  logic [3:0] red, green, blue;
  logic       hs_out, vs_out, blank_out;

  int vectors     = 0;
  int miscompares = 0;

  slap_palette_pipe dut (
    .clk      (clk),
    .reset    (reset),
    .pix_ce   (pix_ce),
    .fix_pix  (fix_pix),
    .spr_pix  (spr_pix),
    .bg_pix   (bg_pix),
    .layer_en (layer_en),
    .hblank   (hblank),
    .vblank   (vblank),
    .hsync    (hsync),
    .vsync    (vsync),
    .prom_addr(prom_addr),
    .prom_n_cs(prom_n_cs),
    .prom_r   (prom_r),
    .prom_g   (prom_g),
    .prom_b   (prom_b),
    .red      (red),
    .green    (green),
    .blue     (blue),
    .hs_out   (hs_out),
    .vs_out   (vs_out),
    .blank_out(blank_out)
  );

  // 10 ns system clock.
  always #5 clk = ~clk;

  // Registered colour PROMs: latch data only while selected.
  always @(posedge clk) begin
    if (!prom_n_cs) begin
      prom_r <= prom_addr[3:0];
      prom_g <= prom_addr[7:4];
      prom_b <= ~prom_addr[3:0];
    end
  end

  // Colour the PROM model returns for a given palette index.
  function automatic logic [11:0] promColour(input logic [7:0] idx);
    return {idx[3:0], idx[7:4], ~idx[3:0]};
  endfunction

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single comparison point: counts and reports any miscompare.
  task automatic checkVal(input string tag, input logic [11:0] obs,
                          input logic [11:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare colour and aligned timing {hs,vs,blank}.
  task automatic checkOutput(input string tag, input logic [11:0] exp_rgb,
                             input logic exp_hs, input logic exp_vs,
                             input logic exp_blank);
    checkVal({tag, ".rgb"}, {red, green, blue}, exp_rgb);
    checkVal({tag, ".timing"}, {9'd0, hs_out, vs_out, blank_out},
             {9'd0, exp_hs, exp_vs, exp_blank});
  endtask

  // Put one pixel's worth of inputs on the bus.
  task automatic applyStimulus(input logic [7:0] fx, input logic [7:0] sp,
                               input logic [7:0] bg, input logic [2:0] en,
                               input logic hb, input logic vb,
                               input logic hs, input logic vs);
    fix_pix  = fx;
    spr_pix  = sp;
    bg_pix   = bg;
    layer_en = en;
    hblank   = hb;
    vblank   = vb;
    hsync    = hs;
    vsync    = vs;
  endtask

  // One isolated pixel: check PROM access then the output two clocks later.
  task automatic sendPixel(input string tag, input logic [7:0] fx,
                           input logic [7:0] sp, input logic [7:0] bg,
                           input logic [2:0] en, input logic [7:0] exp_idx,
                           input logic [11:0] exp_rgb);
    applyStimulus(fx, sp, bg, en, 1'b0, 1'b0, 1'b0, 1'b0);
    pix_ce = 1'b1;
    tick();
    pix_ce = 1'b0;
    checkVal({tag, ".addr"}, {4'd0, prom_addr}, {4'd0, exp_idx});
    checkVal({tag, ".ncs_lo"}, {11'd0, prom_n_cs}, 12'd0);
    tick();
    checkVal({tag, ".ncs_hi"}, {11'd0, prom_n_cs}, 12'd1);
    tick();
    checkOutput(tag, exp_rgb, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [11:0] prev_rgb;
    logic [7:0]  pulse_bg [3];
    pulse_bg[0] = 8'h5A;
    pulse_bg[1] = 8'hC3;
    pulse_bg[2] = 8'h81;

    $display("[TB] start");
    reset  = 1'b1;
    pix_ce = 1'b0;
    applyStimulus(8'h00, 8'h00, 8'h00, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("reset", 12'h000, 1'b0, 1'b0, 1'b1);
    checkVal("reset.ncs", {11'd0, prom_n_cs}, 12'd1);
    checkVal("reset.addr", {4'd0, prom_addr}, 12'd0);
    reset = 1'b0;
    tick();

    // Priority and transparency.
    sendPixel("fix_wins", 8'h35, 8'h47, 8'h12, 3'b111, 8'h35, 12'h53A);
    sendPixel("spr_wins", 8'h30, 8'h47, 8'h12, 3'b111, 8'h47, 12'h748);
    sendPixel("bg_wins",  8'h30, 8'h40, 8'h12, 3'b111, 8'h12, 12'h21D);
    sendPixel("all_off",  8'h35, 8'h47, 8'h12, 3'b000, 8'h00, 12'h00F);
    sendPixel("fix_off",  8'h35, 8'h47, 8'h12, 3'b011, 8'h47, 12'h748);
    sendPixel("bg_only",  8'h35, 8'h47, 8'h12, 3'b001, 8'h12, 12'h21D);
    sendPixel("fix_clr",  8'h30, 8'h47, 8'h12, 3'b100, 8'h00, 12'h00F);

    // Vertical blank with vsync: RGB forced to the blank colour.
    applyStimulus(8'h00, 8'h00, 8'h99, 3'b001, 1'b0, 1'b1, 1'b0, 1'b1);
    pix_ce = 1'b1;
    tick();
    pix_ce = 1'b0;
    tick();
    tick();
    checkOutput("vblank", 12'h000, 1'b0, 1'b1, 1'b1);

    // 16-pixel ramp at one pixel per clock, hblank+hsync on pixels 10-12.
    for (int k = 0; k < 18; k++) begin
      if (k < 16) begin
        applyStimulus(8'h00, 8'h00, 8'(k), 3'b001, (k >= 10 && k <= 12),
                      1'b0, (k >= 10 && k <= 12), 1'b0);
        pix_ce = 1'b1;
      end else begin
        pix_ce = 1'b0;
      end
      tick();
      if (k == 5)
        checkVal("ramp.ncs", {11'd0, prom_n_cs}, 12'd0);
      if (k >= 2) begin
        if (k - 2 >= 10 && k - 2 <= 12)
          checkOutput($sformatf("ramp%0d", k - 2), 12'h000, 1'b1, 1'b0, 1'b1);
        else
          checkOutput($sformatf("ramp%0d", k - 2), promColour(8'(k - 2)),
                      1'b0, 1'b0, 1'b0);
      end
    end

    // Sparse pixel clock: one pulse every 4 clocks.
    prev_rgb = promColour(8'h0F);
    for (int p = 0; p < 3; p++) begin
      applyStimulus(8'h00, 8'h00, pulse_bg[p], 3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
      pix_ce = 1'b1;
      tick();
      pix_ce = 1'b0;
      checkVal($sformatf("sparse%0d.ncs0", p), {11'd0, prom_n_cs}, 12'd0);
      checkVal($sformatf("sparse%0d.hold0", p), {red, green, blue}, prev_rgb);
      tick();
      checkVal($sformatf("sparse%0d.ncs1", p), {11'd0, prom_n_cs}, 12'd1);
      checkVal($sformatf("sparse%0d.hold1", p), {red, green, blue}, prev_rgb);
      tick();
      checkOutput($sformatf("sparse%0d", p), promColour(pulse_bg[p]),
                  1'b0, 1'b0, 1'b0);
      tick();
      checkVal($sformatf("sparse%0d.ncs3", p), {11'd0, prom_n_cs}, 12'd1);
      checkVal($sformatf("sparse%0d.hold3", p), {red, green, blue},
               promColour(pulse_bg[p]));
      prev_rgb = promColour(pulse_bg[p]);
    end

    // Reset with two pixels in flight.
    applyStimulus(8'h00, 8'h00, 8'h77, 3'b001, 1'b0, 1'b0, 1'b1, 1'b1);
    pix_ce = 1'b1;
    tick();
    applyStimulus(8'h00, 8'h00, 8'h66, 3'b001, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    pix_ce = 1'b0;
    reset  = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("midreset", 12'h000, 1'b0, 1'b0, 1'b1);
    checkVal("midreset.ncs", {11'd0, prom_n_cs}, 12'd1);
    tick();
    tick();
    tick();
    checkOutput("no_stale", 12'h000, 1'b0, 1'b0, 1'b1);
    sendPixel("post_reset", 8'h00, 8'h00, 8'h12, 3'b001, 8'h12, 12'h21D);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
